pixel_fetch_4c: RTL and testbench
=================================

# pixel_fetch_4c

Pixel fetch controller for the 4-colour (2 bpp) display path. It reads a packed 2 bpp image from a synchronous 16-bit word memory and keeps one word of prefetch per line. Each active pixel it delivers a 2-bit colour index and an on flag, one cycle after `i_de`, to the 4-colour palette. It sits between the VGA timing generator and the palette. It is the only master of the image memory read port.

## Interface

Parameters:
- `IMG_W`, default 160: image width in pixels; multiple of 8, ≥ 16.
- `IMG_H`, default 120: image height in lines.
- `AW`, default 12: memory word address width; must satisfy 2^AW ≥ IMG_W/8·IMG_H.

Ports:
- `i_clk`: input, 1 bit. Pixel clock; all state changes on its rising edge.
- `i_rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `i_frame_start`: input, 1 bit. One-cycle pulse, once per frame, before the first line's `i_line_start`.
- `i_line_start`: input, 1 bit. One-cycle pulse per line, during horizontal blanking, ≥ 3 cycles before that line's first `i_de`.
- `i_de`: input, 1 bit. Display enable; high for each active pixel.
- `o_rd`: output, 1 bit. Memory read strobe.
- `o_addr`: output, AW bits. Memory word address; valid while `o_rd` is high.
- `i_data`: input, 16 bits. Memory read data, valid exactly 1 cycle after `o_rd`.
- `o_color`: output, 2 bits. Palette colour index.
- `o_on`: output, 1 bit. Pixel is inside the image; drives the palette's on input.

## Operation

Memory format:
- WPL = IMG_W/8 words per line.
- Word n of line y is at address y·WPL + n.
- Leftmost pixel is in bits [15:14], MSB first.

Internal state:
- `line_cnt`: cleared by `i_frame_start`; incremented at every `i_line_start`. It selects the line being set up.
- `base`: address of word 0 of the current line. Cleared by `i_frame_start`. On `i_line_start`, `base += WPL` if the previous line was an image line. No multiplier.
- A line is an image line when `line_cnt < IMG_H`.
- Also kept: 16-bit `shift` register, 16-bit `next` register, 3-bit pixel-in-word counter, column counter, words-issued counter.

State machine:
- **IDLE**: reset state and non-image lines. `o_rd` = 0. On `i_line_start` of an image line: issue `o_addr = base` and go to FILL0.
- **FILL0**: `shift <= i_data`; issue `base+1`; go to FILL1.
- **FILL1**: `next <= i_data`; go to RUN. Pixel counter = 0, column = 0, words issued = 2.
- **RUN**: on each `i_de` cycle:
  - output `shift[15:14]`; shift left by 2; column++, pixel counter++.
  - When pixel counter = 7: `shift <= next`. If words issued < WPL, issue the next word; its data lands in `next` the following cycle.
  - Cycles with `i_de` low hold all state, so gaps are allowed.
  - When column reaches IMG_W, go to DONE.
- **DONE**: no reads; wait for `i_line_start`.

Image region and outputs:
- `o_on` is high only for `i_de` cycles in RUN with column < IMG_W.
- `o_color` is 0 whenever `o_on` is 0.
- Pixels to the right of or below the image give `o_on` = 0.

Boundary cases:
- `i_line_start` in any state aborts the current line and restarts from IDLE semantics for the new line.
- Simultaneous `i_frame_start` and `i_line_start`: frame start is applied first, then line 0 is set up (fetch of address 0).
- `i_frame_start` mid-line: go to IDLE, clear `line_cnt` and `base`.
- No read is ever issued past word WPL−1 of a line or for lines ≥ IMG_H.

## Timing

- Reset: all outputs 0. State IDLE, all counters and registers 0.
- Read latency is fixed at 1 cycle; no back-pressure.
- Pixel latency: `o_color`/`o_on` are registered and correspond to `i_de` one cycle earlier.
- Fetch: 2 reads at line setup (consecutive cycles), then at most one read per 8 active pixels.
- Peak read rate: 1 read per cycle, FILL0 to FILL1 only.
- Line setup completes 3 cycles after `i_line_start`.

## Structure

Shared package `vga_4c_pkg` holds:
- `BPP` = 2
- `PIX_PER_WORD` = 8
- the state enum (IDLE, FILL0, FILL1, RUN, DONE)
- `color_idx_t` (2 bits)

Natural sub-module: `pix_shreg_2bpp`. It contains the `shift`/`next` pair and the pixel-in-word counter. Control inputs are load, shift and reload; outputs are the current index and a last-pixel flag.

## Test plan

- **Reset.** Assert `i_rst_n` = 0 mid-RUN, release, then run line 0 with words 0xE4E4 and 0x1B1B. Required: all outputs 0 during reset; then `o_color` sequence 3,2,1,0,3,2,1,0,0,1,2,3… with `o_on` = 1, each one cycle after `i_de`.
- **Addressing.** IMG_W = 160, line_cnt = 5. Required: reads at 100, 101, …, 119 only; no read 120.
- **Right edge.** `i_de` held for 640 pixels. Required: `o_on` = 1 for exactly 160 cycles, then 0 with `o_color` = 0; no further reads.
- **Bottom edge.** Line 120 (= IMG_H). Required: zero reads, `o_on` = 0 for the whole line. Next `i_frame_start` plus line: read address 0.
- **`i_de` gaps.** `i_de` toggling 1/0 within a word. Required: identical colour sequence to the gap-free case, delayed by the gaps; no pixel skipped or repeated.
- **Abort.** `i_line_start` mid-RUN, and a simultaneous `i_frame_start` + `i_line_start`. Required: next reads at `base+WPL`, and at 0 respectively.

Source files
------------

// File: rtl/vga_4c_pkg.sv
// Shared definitions for the 4-colour (2 bpp) display path.
//   BPP          : bits per pixel in the packed image
//   PIX_PER_WORD : pixels held by one 16-bit image word
//   fetch_state_t: pixel fetch controller states
//   color_idx_t  : palette colour index
package vga_4c_pkg;

    localparam int BPP          = 2;
    localparam int PIX_PER_WORD = 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL0,
        FILL1,
        RUN,
        DONE
    } fetch_state_t;

    typedef logic [BPP-1:0] color_idx_t;

endpackage

// File: rtl/pixel_fetch_4c_if.sv
// Image memory read port (synchronous, 1-cycle read latency).
//   rd   : read strobe (master -> memory)
//   addr : word address, valid while rd is high (master -> memory)
//   data : read data, valid the cycle after rd (memory -> master)
interface pixel_fetch_4c_if #(
    parameter int AW = 12
);

    logic          rd;
    logic [AW-1:0] addr;
    logic [15:0]   data;

    modport master (output rd, output addr, input data);
    modport slave  (input rd, input addr, output data);

endinterface

// File: rtl/pix_shreg_2bpp.sv
// Two-word pixel shifter for 2 bpp packed words, MSB pixel first.
//   i_load   : shift <= i_data, pixel counter <= 0 (line setup)
//   i_reload : next <= i_data (prefetch word arriving from memory)
//   i_shift  : advance one pixel; after the 8th pixel shift <= next
//   o_idx    : colour index of the current pixel
//   o_last   : current pixel is the last one of the word
module pix_shreg_2bpp
    import vga_4c_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_reload,
    input  logic        i_shift,
    input  logic [15:0] i_data,
    output color_idx_t  o_idx,
    output logic        o_last
);

    logic [15:0] shift_q, shift_d;
    logic [15:0] next_q, next_d;
    logic [2:0]  pix_q, pix_d;

    always_comb begin
        shift_d = shift_q;
        next_d  = next_q;
        pix_d   = pix_q;
        if (i_load) begin
            shift_d = i_data;
            pix_d   = '0;
        end else if (i_shift) begin
            if (o_last) begin
                shift_d = next_q;
                pix_d   = '0;
            end else begin
                shift_d = {shift_q[15-BPP:0], {BPP{1'b0}}};
                pix_d   = pix_q + 3'd1;
            end
        end
        if (i_reload) begin
            next_d = i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            next_q  <= '0;
            pix_q   <= '0;
        end else begin
            shift_q <= shift_d;
            next_q  <= next_d;
            pix_q   <= pix_d;
        end
    end

    assign o_idx  = shift_q[15:16-BPP];
    assign o_last = (pix_q == 3'(PIX_PER_WORD - 1));

endmodule

// File: rtl/pixel_fetch_4c.sv
// Pixel fetch controller: reads a packed 2 bpp image line by line from
// a synchronous word memory (one word of prefetch) and delivers one
// registered colour index per active pixel, one cycle after i_de.
//   i_clk, i_rst_n   : pixel clock, async active-low reset
//   i_frame_start    : frame pulse, restarts at line 0 / address 0
//   i_line_start     : line pulse, sets up the next line (aborts any line)
//   i_de             : display enable, one pixel per high cycle
//   mem              : image memory read port (master)
//   o_color, o_on    : palette colour index and inside-image flag
module pixel_fetch_4c
    import vga_4c_pkg::*;
#(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_frame_start,
    input  logic                    i_line_start,
    input  logic                    i_de,
    pixel_fetch_4c_if.master        mem,
    output color_idx_t              o_color,
    output logic                    o_on
);

    localparam int WPL = IMG_W / PIX_PER_WORD;
    localparam int CW  = $clog2(IMG_W + 1);
    localparam int WW  = $clog2(WPL + 1);
    localparam int LW  = $clog2(IMG_H + 1);

    fetch_state_t  state_q, state_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [AW-1:0] base_q, base_d;      // word 0 address of the next image line
    logic [AW-1:0] waddr_q, waddr_d;    // next word address to issue
    logic [CW-1:0] col_q, col_d;
    logic [WW-1:0] words_q, words_d;
    logic          pend_q, pend_d;      // prefetch data lands this cycle
    color_idx_t    color_q, color_d;
    logic          on_q, on_d;

    logic          rd;
    logic [AW-1:0] addr;
    logic          sr_load, sr_reload, sr_shift;
    color_idx_t    sr_idx;
    logic          sr_last;
    logic [LW-1:0] line_eff;
    logic [AW-1:0] base_eff;

    pix_shreg_2bpp u_shreg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (sr_load),
        .i_reload (sr_reload),
        .i_shift  (sr_shift),
        .i_data   (mem.data),
        .o_idx    (sr_idx),
        .o_last   (sr_last)
    );

    always_comb begin
        state_d    = state_q;
        line_cnt_d = line_cnt_q;
        base_d     = base_q;
        waddr_d    = waddr_q;
        col_d      = col_q;
        words_d    = words_q;
        pend_d     = 1'b0;
        color_d    = '0;
        on_d       = 1'b0;
        rd         = 1'b0;
        addr       = waddr_q;
        sr_load    = 1'b0;
        sr_reload  = pend_q;
        sr_shift   = 1'b0;
        line_eff   = line_cnt_q;
        base_eff   = base_q;

        // Frame start is applied before a coincident line start, so the
        // line set up in the same cycle is line 0 at address 0.
        if (i_frame_start) begin
            state_d    = IDLE;
            line_cnt_d = '0;
            base_d     = '0;
            line_eff   = '0;
            base_eff   = '0;
        end

        if (i_line_start) begin
            if (line_eff != LW'(IMG_H)) begin
                line_cnt_d = line_eff + LW'(1);
            end
            if (line_eff < LW'(IMG_H)) begin
                rd      = 1'b1;
                addr    = base_eff;
                waddr_d = base_eff + AW'(1);
                base_d  = base_eff + AW'(WPL);
                state_d = FILL0;
            end else begin
                state_d = IDLE;
            end
        end else if (!i_frame_start) begin
            case (state_q)
                FILL0: begin
                    sr_load = 1'b1;
                    rd      = 1'b1;
                    waddr_d = waddr_q + AW'(1);
                    state_d = FILL1;
                end
                FILL1: begin
                    sr_reload = 1'b1;
                    col_d     = '0;
                    words_d   = WW'(2);
                    state_d   = RUN;
                end
                RUN: begin
                    if (i_de) begin
                        on_d     = 1'b1;
                        color_d  = sr_idx;
                        sr_shift = 1'b1;
                        col_d    = col_q + CW'(1);
                        if (sr_last && (words_q < WW'(WPL))) begin
                            rd      = 1'b1;
                            waddr_d = waddr_q + AW'(1);
                            words_d = words_q + WW'(1);
                            pend_d  = 1'b1;
                        end
                        if (col_q == CW'(IMG_W - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            line_cnt_q <= '0;
            base_q     <= '0;
            waddr_q    <= '0;
            col_q      <= '0;
            words_q    <= '0;
            pend_q     <= 1'b0;
            color_q    <= '0;
            on_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_cnt_q <= line_cnt_d;
            base_q     <= base_d;
            waddr_q    <= waddr_d;
            col_q      <= col_d;
            words_q    <= words_d;
            pend_q     <= pend_d;
            color_q    <= color_d;
            on_q       <= on_d;
        end
    end

    assign mem.rd   = rd;
    assign mem.addr = addr;
    assign o_color  = color_q;
    assign o_on     = on_q;

endmodule

// File: tb/tb_pixel_fetch_4c.sv
// Directed self-checking bench for pixel_fetch_4c (160x120, 20 words/line).
module tb_pixel_fetch_4c;
    import vga_4c_pkg::*;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int AW    = 12;
    localparam int WPL   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       line_start = 1'b0;
    logic       de = 1'b0;
    color_idx_t color;
    logic       on;

    pixel_fetch_4c_if #(.AW(AW)) mem_if ();

    pixel_fetch_4c #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_line_start  (line_start),
        .i_de          (de),
        .mem           (mem_if),
        .o_color       (color),
        .o_on          (on)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];

    always @(posedge clk) begin
        if (mem_if.rd) mem_if.data <= mem[mem_if.addr];
    end

    int unsigned rd_log[$];
    color_idx_t  pix_log[$];
    int          on_cnt = 0;
    int          bad_off = 0;
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    always @(posedge clk) begin
        if (rst_n && mem_if.rd) rd_log.push_back(int'(mem_if.addr));
    end

    always @(negedge clk) begin
        if (on) begin
            pix_log.push_back(color);
            on_cnt++;
        end else if (color !== 2'b00) begin
            bad_off++;
        end
    end

    task automatic step(input logic fs, input logic ls, input logic d);
        @(negedge clk);
        frame_start = fs;
        line_start  = ls;
        de          = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_logs();
        rd_log.delete();
        pix_log.delete();
        on_cnt  = 0;
        bad_off = 0;
    endtask

    task automatic start_line();
        step(1'b0, 1'b1, 1'b0);
        idle(4);
    endtask

    // n active pixels; with gap set, pixel i is followed by i%3 idle cycles
    task automatic pixels(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (gap) for (int g = 0; g < i % 3; g++) step(1'b0, 1'b0, 1'b0);
        end
        idle(3);
    endtask

    function automatic color_idx_t exp_pix(int y, int x);
        logic [15:0] w;
        w = mem[y * WPL + x / 8];
        w = w >> (14 - 2 * (x % 8));
        return w[1:0];
    endfunction

    function automatic int pix_errs(int y, int n);
        int e = 0;
        if (pix_log.size() != n) return n + 1;
        for (int i = 0; i < n; i++) if (pix_log[i] !== exp_pix(y, i)) e++;
        return e;
    endfunction

    function automatic int rd_at(int i);
        if (i < rd_log.size()) return int'(rd_log[i]);
        return -1;
    endfunction

    task automatic test_reset();
        color_idx_t exp_seq [12];
        int e;
        exp_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        idle(2);
        chk_cnt++; if (mem_if.rd !== 1'b0) $display("FAIL reset_rd: got %b expected 0", mem_if.rd); else pass_cnt++;
        chk_cnt++; if (on !== 1'b0) $display("FAIL reset_on: got %b expected 0", on); else pass_cnt++;
        chk_cnt++; if (color !== 2'd0) $display("FAIL reset_color: got %0d expected 0", color); else pass_cnt++;
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        start_line();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({mem_if.rd, on, color} !== 4'b0)
            $display("FAIL reset_midrun: got rd=%b on=%b color=%0d expected all 0", mem_if.rd, on, color);
        else pass_cnt++;
        idle(3);
        chk_cnt++;
        if ({mem_if.rd, on, color} !== 4'b0)
            $display("FAIL reset_hold: got rd=%b on=%b color=%0d expected all 0", mem_if.rd, on, color);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        clear_logs();
        start_line();
        step(1'b0, 1'b0, 1'b1);
        #1;
        chk_cnt++; if (on !== 1'b0) $display("FAIL latency_early: got on=%b expected 0", on); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (on !== 1'b1 || color !== 2'd3)
            $display("FAIL latency_first: got on=%b color=%0d expected on=1 color=3", on, color);
        else pass_cnt++;
        for (int i = 1; i < 12; i++) step(1'b0, 1'b0, 1'b1);
        idle(3);
        e = (pix_log.size() == 12) ? 0 : 100;
        for (int i = 0; i < 12 && i < pix_log.size(); i++) if (pix_log[i] !== exp_seq[i]) e++;
        chk_cnt++; if (e != 0) $display("FAIL reset_seq: got %0d bad of %0d pixels expected 0 bad of 12", e, pix_log.size()); else pass_cnt++;
        chk_cnt++;
        if (rd_log.size() != 3 || rd_at(0) != 0 || rd_at(1) != 1 || rd_at(2) != 2)
            $display("FAIL reset_reads: got n=%0d first=%0d,%0d,%0d expected n=3 0,1,2", rd_log.size(), rd_at(0), rd_at(1), rd_at(2));
        else pass_cnt++;
    endtask

    task automatic test_addressing();
        int e = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int l = 0; l < 5; l++) start_line();
        idle(2);
        clear_logs();
        start_line();
        pixels(IMG_W, 1'b0);
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != 100 + i) e++;
        chk_cnt++;
        if (rd_log.size() != 20 || e != 0)
            $display("FAIL addr_line5: got n=%0d bad=%0d expected 20 reads 100..119", rd_log.size(), e);
        else pass_cnt++;
        e = pix_errs(5, IMG_W);
        chk_cnt++; if (e != 0) $display("FAIL addr_pixels: got %0d bad expected 0", e); else pass_cnt++;
    endtask

    task automatic test_right_edge();
        int e;
        clear_logs();
        start_line();
        pixels(640, 1'b0);
        chk_cnt++; if (on_cnt != IMG_W) $display("FAIL edge_on_cnt: got %0d expected %0d", on_cnt, IMG_W); else pass_cnt++;
        chk_cnt++; if (bad_off != 0) $display("FAIL edge_off_color: got %0d nonzero expected 0", bad_off); else pass_cnt++;
        chk_cnt++;
        if (rd_log.size() != 20 || rd_at(0) != 120 || rd_at(19) != 139)
            $display("FAIL edge_reads: got n=%0d first=%0d last=%0d expected 20 120 139", rd_log.size(), rd_at(0), rd_at(19));
        else pass_cnt++;
        e = pix_errs(6, IMG_W);
        chk_cnt++; if (e != 0) $display("FAIL edge_pixels: got %0d bad expected 0", e); else pass_cnt++;
    endtask

    task automatic test_bottom_edge();
        step(1'b1, 1'b0, 1'b0);
        for (int l = 0; l < IMG_H - 1; l++) start_line();
        idle(2);
        clear_logs();
        start_line();
        chk_cnt++;
        if (rd_log.size() != 2 || rd_at(0) != 2380 || rd_at(1) != 2381)
            $display("FAIL bottom_line119: got n=%0d %0d,%0d expected 2 2380,2381", rd_log.size(), rd_at(0), rd_at(1));
        else pass_cnt++;
        clear_logs();
        start_line();
        pixels(200, 1'b0);
        chk_cnt++; if (rd_log.size() != 0) $display("FAIL bottom_reads: got %0d expected 0", rd_log.size()); else pass_cnt++;
        chk_cnt++; if (on_cnt != 0 || bad_off != 0) $display("FAIL bottom_on: got on=%0d badcolor=%0d expected 0 0", on_cnt, bad_off); else pass_cnt++;
        step(1'b1, 1'b0, 1'b0);
        clear_logs();
        start_line();
        chk_cnt++;
        if (rd_log.size() != 2 || rd_at(0) != 0 || rd_at(1) != 1)
            $display("FAIL bottom_newframe: got n=%0d %0d,%0d expected 2 0,1", rd_log.size(), rd_at(0), rd_at(1));
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        int e;
        step(1'b1, 1'b0, 1'b0);
        clear_logs();
        start_line();
        pixels(32, 1'b1);
        e = pix_errs(0, 32);
        chk_cnt++; if (e != 0) $display("FAIL gaps_pixels: got %0d bad of %0d expected 0 of 32", e, pix_log.size()); else pass_cnt++;
        chk_cnt++;
        if (rd_log.size() != 6 || rd_at(2) != 2 || rd_at(5) != 5)
            $display("FAIL gaps_reads: got n=%0d third=%0d last=%0d expected 6 2 5", rd_log.size(), rd_at(2), rd_at(5));
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int e;
        step(1'b1, 1'b0, 1'b0);
        start_line();
        clear_logs();
        start_line();
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);
        idle(3);
        e = pix_errs(1, 30);
        chk_cnt++; if (e != 0) $display("FAIL abort_line1_pixels: got %0d bad expected 0", e); else pass_cnt++;
        clear_logs();
        start_line();
        chk_cnt++;
        if (rd_log.size() != 2 || rd_at(0) != 40 || rd_at(1) != 41)
            $display("FAIL abort_midrun: got n=%0d %0d,%0d expected 2 40,41", rd_log.size(), rd_at(0), rd_at(1));
        else pass_cnt++;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        idle(2);
        clear_logs();
        step(1'b1, 1'b1, 1'b0);
        idle(4);
        chk_cnt++;
        if (rd_log.size() != 2 || rd_at(0) != 0 || rd_at(1) != 1)
            $display("FAIL abort_frame_line: got n=%0d %0d,%0d expected 2 0,1", rd_log.size(), rd_at(0), rd_at(1));
        else pass_cnt++;
        pixels(16, 1'b0);
        e = pix_errs(0, 16);
        chk_cnt++; if (e != 0) $display("FAIL abort_line0_pixels: got %0d bad expected 0", e); else pass_cnt++;
        clear_logs();
        start_line();
        chk_cnt++;
        if (rd_at(0) != 20) $display("FAIL abort_following_line: got %0d expected 20", rd_at(0)); else pass_cnt++;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'(a * 32'h9E37 + 32'h1234);
        mem[0] = 16'hE4E4;
        mem[1] = 16'h1B1B;
        test_reset();
        test_addressing();
        test_right_edge();
        test_bottom_edge();
        test_gaps();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
